// File: rtl/pkg_display.sv
// Shared display types and the hex-to-7-segment table.
// Segment encoding is {g,f,e,d,c,b,a}, active-low.
package pkg_display;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry [n] holds the glyph for hex value n (entry 15 is listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/modulo_decodificador_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module modulo_decodificador_7seg
  import pkg_display::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = decode(nibble);

endmodule

// File: rtl/modulo_varredura_display.sv
// Scans N_DIGITS hex digits onto a common-anode 7-segment display, paced by one divider tap.
// Optional macro LEADING_ZERO_BLANK_EN suppresses the segments of leading zero digits.
module modulo_varredura_display
  import pkg_display::*;
#(
  parameter int unsigned TAP_SEL      = 16,
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [19:0]           q_div,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [N_DIGITS-1:0]   anodo,
  output logic [6:0]            segmentos,
  output logic                  dp,
  output logic                  scan_tick
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(BLANK_CYCLES + 1);

  logic s1, s2, s3;
  logic unused_q_div;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [CNT_W-1:0]    blank_cnt, blank_cnt_d;
  logic [N_DIGITS-1:0] anodo_d;
  logic [6:0]          segmentos_d;
  logic                dp_d;

  logic [3:0] nibble_c;
  logic       dp_sel_c;
  logic       suppress_c;
  logic [6:0] glyph_c;

  assign unused_q_div = ^q_div;

  // Tap synchroniser; deliberately not reset so a tap already high at release gives no tick.
  always_ff @(posedge clk) begin
    s1 <= q_div[TAP_SEL];
    s2 <= s1;
    s3 <= s2;
  end

  assign scan_tick = s2 & ~s3 & ~clr;

  // Select the nibble and decimal point of the digit currently being scanned.
  always_comb begin
    nibble_c = 4'h0;
    dp_sel_c = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (IDX_W'(i) == idx) begin
        nibble_c = digits[4*i +: 4];
        dp_sel_c = dp_in[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero_c;

  // True when this digit and every more significant digit are zero.
  always_comb begin
    upper_zero_c = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if ((IDX_W'(i) >= idx) && (digits[4*i +: 4] != 4'h0)) begin
        upper_zero_c = 1'b0;
      end
    end
  end

  assign suppress_c = upper_zero_c && (idx != '0);
`else
  assign suppress_c = 1'b0;
`endif

  modulo_decodificador_7seg u_decodificador (
    .nibble (nibble_c),
    .seg_c  (glyph_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    blank_cnt_d = blank_cnt;
    anodo_d     = '1;
    segmentos_d = SEG_OFF;
    dp_d        = 1'b1;

    if (scan_tick) begin
      idx_d       = (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      state_d     = BLANK;
      blank_cnt_d = '0;
    end else begin
      case (state)
        BLANK: begin
          blank_cnt_d = blank_cnt + CNT_W'(1);
          if (blank_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
          end
        end
        SHOW: ;
        default: state_d = BLANK;
      endcase
    end

    if (state == SHOW) begin
      anodo_d     = ~(N_DIGITS'(1) << idx);
      segmentos_d = suppress_c ? SEG_OFF : glyph_c;
      dp_d        = ~dp_sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= BLANK;
      idx       <= '0;
      blank_cnt <= '0;
      anodo     <= '1;
      segmentos <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      blank_cnt <= blank_cnt_d;
      anodo     <= anodo_d;
      segmentos <= segmentos_d;
      dp        <= dp_d;
    end
  end

endmodule

// File: doc/modulo_varredura_display.md
Name: modulo_varredura_display

Overview:
Downstream consumer of the 20-bit frequency-divider tap bus. It turns one selected divider tap into a single-cycle scan tick, then time-multiplexes N_DIGITS hex digits onto a common-anode 7-segment display. A short anode-off blanking interval after each digit switch suppresses ghosting. All logic runs on the board clock; divider taps are treated as asynchronous data, never used as clocks.

Parameters:
TAP_SEL, 16, index (0..19) of the divider tap used as scan rate source
N_DIGITS, 4, number of multiplexed digits (2..4)
BLANK_CYCLES, 8, clk cycles with all anodes off after each digit switch (>=1)

Ports:
clk  input  1  board clock; single clock domain
clr  input  1  reset; synchronous, active-high
q_div  input  20  divider tap bus; bit k toggles at F/2^(k+1)
digits  input  4*N_DIGITS  hex nibbles; digit i = digits[4i+3:4i], digit 0 rightmost
dp_in  input  N_DIGITS  decimal point per digit, active-high
anodo  output  N_DIGITS  digit enables, active-low, one-hot-low in SHOW
segmentos  output  7  {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
scan_tick  output  1  one-cycle pulse per selected-tap rising edge, for observation

Behaviour:
- Sync chain s1->s2->s3 samples q_div[TAP_SEL] every clk and is not reset. scan_tick = s2 & ~s3, forced 0 while clr=1.
- Because the chain is not reset, a tap already high at clr release produces no spurious tick.
- Tap rise to scan_tick: 2-3 clk. scan_tick is high exactly 1 clk per tap rising edge.
- Registers: idx (0..N_DIGITS-1), state {BLANK, SHOW}, blank_cnt (clog2(BLANK_CYCLES+1) bits).
- Reset (clr sampled high at a clk edge): idx=0, state=BLANK, blank_cnt=0, anodo=all 1, segmentos=7'b1111111, dp=1.
- clr mid-operation: the same values load on the next edge, aborting any blank or show phase.
- On scan_tick=1 in any state: idx <= (idx==N_DIGITS-1) ? 0 : idx+1, state <= BLANK, blank_cnt <= 0.
- A tick during BLANK restarts the blank interval.
- BLANK with no tick: blank_cnt increments. When blank_cnt==BLANK_CYCLES-1, state <= SHOW.
- SHOW with no tick: hold.
- Outputs are registered from the current state, idx, digits and dp_in, so they lag by 1 clk.
- Output in BLANK: anodo all 1, segmentos all 1, dp=1.
- Output in SHOW: anodo bit idx = 0 and all others 1. segmentos = decode(digit idx). dp = ~dp_in[idx].
- digits and dp_in are resampled every cycle in SHOW; a change appears 1 clk later.
- Decode (active-low {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- From reset to first lit digit: BLANK_CYCLES + 1 clk (digit 0), even with no tick.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN
- Defined: in SHOW, if digit idx and every digit above it are 0 and idx != 0, segmentos = 1111111. The anode is still driven and dp still follows dp_in. Digit 0 is always shown.
- Undefined: every digit is decoded normally; no extra logic.

Decomposition:
- Package pkg_display: state enum {BLANK, SHOW}, SEG_OFF = 7'b1111111, the 16-entry hex-to-segment constant table, and a decode function.
- One combinational sub-module, modulo_decodificador_7seg (4-bit in, 7-bit active-low out), built on the package table. It is also reusable elsewhere in the design.

Test Plan:
1. clr=1 for 3 clk, then release with q_div=0 -> anodo=1111, segmentos=1111111, dp=1; after 9 clk anodo=1110 with digits=16'h4321 -> segmentos=1111001 (digit "1").
2. Toggle q_div[16] with period 64 clk, digits=16'h4321 -> anodo sequence 1110, 1101, 1011, 0111, 1110 (wrap 3->0); segments 1, 2, 3, 4; each switch preceded by 8 clk of anodo=1111.
3. Hold q_div[16]=1 through clr and release -> no scan_tick within 20 clk; the first tick comes only after the next 0->1 transition.
4. Two tap rises 5 clk apart (inside the blank window) -> idx advances twice, blank restarts at the second tick, SHOW resumes 8 clk after it.
5. digits=16'h00F0, dp_in=4'b0010 -> digit1 segmentos=0001110, dp=0; digit3/digit2 show 1000000 (macro off) or 1111111 (LEADING_ZERO_BLANK_EN on); digit0 always shows 1000000.
6. Assert clr for 1 clk while in SHOW on idx=2 -> next edge anodo=1111, idx=0; digit 0 lit BLANK_CYCLES+1 clk after clr drops.
